// File: rtl/if_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// IFStruct - shared fetch-entry type and constants for the IF fetch unit
// Rev 1.0
// ============================================================================
package IFStruct;

   localparam logic [31:0] NOP_INST         = 32'h0000_0013;
   localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] inst;
   } FetchEntry;

   localparam int FETCH_ENTRY_W = $bits(FetchEntry);

   // Sequential fetch advances one word; wraps modulo 2^64 by construction.
   function automatic logic [63:0] next_fetch_pc(input logic [63:0] pc);
      return pc + 64'd4;
   endfunction

endpackage
`default_nettype wire

// File: rtl/if_fetch_fifo.sv
`default_nettype none
// ============================================================================
// if_fetch_fifo - synchronous FetchEntry FIFO with push, pop and clear
// Rev 1.0
// ============================================================================
module if_fetch_fifo
   import IFStruct::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clear,
   input  logic                         push,
   input  logic [FETCH_ENTRY_W-1:0]     push_data,
   input  logic                         pop,
   output logic [FETCH_ENTRY_W-1:0]     head,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         empty,
   output logic                         full
);

   localparam int c_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int c_CNTW = $clog2(DEPTH+1);
   localparam logic [c_CNTW-1:0] c_DEPTH = c_CNTW'(DEPTH);

   FetchEntry         r_mem [DEPTH];
   logic [c_AW-1:0]   r_wr_ptr;
   logic [c_AW-1:0]   r_rd_ptr;
   logic [c_CNTW-1:0] r_count;
   logic              w_do_push;
   logic              w_do_pop;

   assign empty     = (r_count == '0);
   assign full      = (r_count == c_DEPTH);
   assign count     = r_count;
   assign head      = r_mem[r_rd_ptr];
   assign w_do_pop  = pop && !empty;
   // A full FIFO may still accept a push when the head leaves in the same cycle.
   assign w_do_push = push && (!full || w_do_pop);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
         r_count <= r_count + c_CNTW'(w_do_push) - c_CNTW'(w_do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= push_data;
   end

endmodule
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// if_fetch_unit - IF-stage PC owner, imem requester and response buffer;
// IF_FETCH_PERF_EN adds fetch/bubble performance counters.  Rev 1.0
// ============================================================================
module if_fetch_unit
   import IFStruct::*;
#(
   parameter logic [63:0] RESET_PC        = RESET_PC_DEFAULT,
   parameter int          FIFO_DEPTH      = 2,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_if,
   input  logic        redirect,
   input  logic [63:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [63:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic [63:0] pc_if,
   output logic [31:0] inst_if,
   output logic        valid_if
`ifdef IF_FETCH_PERF_EN
   ,
   output logic [63:0] fetch_cnt,
   output logic [63:0] bubble_cnt
`endif
);

   localparam int c_CW  = $clog2(MAX_OUTSTANDING+1);
   localparam int c_FCW = $clog2(FIFO_DEPTH+1);
   localparam int c_SW  = $clog2(FIFO_DEPTH+MAX_OUTSTANDING+1);
   localparam int c_PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam logic [c_CW-1:0] c_MAX_OUT   = c_CW'(MAX_OUTSTANDING);
   localparam logic [c_SW-1:0] c_DEPTH_S   = c_SW'(FIFO_DEPTH);
   localparam logic [c_PW-1:0] c_INFL_LAST = c_PW'(MAX_OUTSTANDING-1);

   logic [63:0]      r_fetch_pc;
   logic [c_CW-1:0]  r_outstanding;
   logic [c_CW-1:0]  r_drop_cnt;
   logic [63:0]      r_infl_pc [MAX_OUTSTANDING];
   logic [c_PW-1:0]  r_infl_wr;
   logic [c_PW-1:0]  r_infl_rd;

   logic             w_req_fire;
   logic             w_rsp_keep;
   logic             w_pop;
   logic [c_CW-1:0]  w_out_next;
   logic [c_SW-1:0]  w_credit_sum;
   logic [c_FCW-1:0] w_fifo_count;
   logic             w_fifo_empty;
   logic             w_fifo_full;
   FetchEntry        w_head;
   FetchEntry        w_push_entry;

   // Credit counts both in-flight and buffered words so every response lands.
   assign w_credit_sum   = c_SW'(r_outstanding) + c_SW'(w_fifo_count);
   assign imem_req_valid = rst && !redirect && (r_outstanding < c_MAX_OUT)
                           && (w_credit_sum < c_DEPTH_S);
   assign imem_req_addr  = r_fetch_pc;
   assign w_req_fire     = imem_req_valid && imem_req_ready;
   assign w_out_next     = r_outstanding + c_CW'(w_req_fire) - c_CW'(imem_rsp_valid);
   assign w_rsp_keep     = imem_rsp_valid && !redirect && (r_drop_cnt == '0);
   assign w_push_entry   = '{pc: r_infl_pc[r_infl_rd], inst: imem_rsp_data};

   assign valid_if = !w_fifo_empty;
   assign pc_if    = w_fifo_empty ? 64'h0 : w_head.pc;
   assign inst_if  = w_fifo_empty ? NOP_INST : w_head.inst;
   assign w_pop    = valid_if && !stall_if;

   if_fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .clear     (redirect),
      .push      (w_rsp_keep),
      .push_data (w_push_entry),
      .pop       (w_pop),
      .head      (w_head),
      .count     (w_fifo_count),
      .empty     (w_fifo_empty),
      .full      (w_fifo_full)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_fetch_pc    <= RESET_PC;
         r_outstanding <= '0;
         r_drop_cnt    <= '0;
      end else begin
         r_outstanding <= w_out_next;
         if (redirect) begin
            r_fetch_pc <= redirect_pc;
            // Everything still in flight after this edge belongs to the old path.
            r_drop_cnt <= w_out_next;
         end else begin
            if (w_req_fire) r_fetch_pc <= next_fetch_pc(r_fetch_pc);
            if (imem_rsp_valid && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - c_CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst || redirect) begin
         r_infl_wr <= '0;
         r_infl_rd <= '0;
      end else begin
         if (w_req_fire) r_infl_wr <= (r_infl_wr == c_INFL_LAST) ? '0 : r_infl_wr + c_PW'(1);
         if (w_rsp_keep) r_infl_rd <= (r_infl_rd == c_INFL_LAST) ? '0 : r_infl_rd + c_PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_req_fire) r_infl_pc[r_infl_wr] <= r_fetch_pc;
   end

`ifdef IF_FETCH_PERF_EN
   logic [63:0] r_fetch_cnt;
   logic [63:0] r_bubble_cnt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_fetch_cnt  <= '0;
         r_bubble_cnt <= '0;
      end else begin
         if (w_pop && (r_fetch_cnt != '1)) r_fetch_cnt <= r_fetch_cnt + 64'd1;
         if (!stall_if && !valid_if && !redirect && (r_bubble_cnt != '1))
            r_bubble_cnt <= r_bubble_cnt + 64'd1;
      end
   end

   assign fetch_cnt  = r_fetch_cnt;
   assign bubble_cnt = r_bubble_cnt;
`endif

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (rst) begin
         assert (!(w_req_fire && (r_outstanding == c_MAX_OUT)));
         assert (!(imem_rsp_valid && (r_outstanding == '0)));
         assert (r_drop_cnt <= r_outstanding);
         assert (!(w_rsp_keep && w_fifo_full && !w_pop));
      end
   end
`endif

endmodule
`default_nettype wire
